// File: rtl/avl_mem_tester_if.sv
// Avalon-MM burst bus between the memory tester and a memory controller.
//   master modport: drives address/burstbegin/burstcount/write/read/writedata,
//                   receives waitrequest_n, readdatavalid, readdata
//   slave modport : the mirror image, used by memory models
interface avl_mem_tester_if #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0] avl_address;
    logic              avl_burstbegin;
    logic [2:0]        avl_burstcount;
    logic              avl_write;
    logic              avl_read;
    logic [DATA_W-1:0] avl_writedata;
    logic              avl_waitrequest_n;
    logic              avl_readdatavalid;
    logic [DATA_W-1:0] avl_readdata;

    modport master (
        output avl_address, avl_burstbegin, avl_burstcount,
        output avl_write, avl_read, avl_writedata,
        input  avl_waitrequest_n, avl_readdatavalid, avl_readdata
    );

    modport slave (
        input  avl_address, avl_burstbegin, avl_burstcount,
        input  avl_write, avl_read, avl_writedata,
        output avl_waitrequest_n, avl_readdatavalid, avl_readdata
    );
endinterface

// File: rtl/avl_mem_tester.sv
// Avalon-MM memory tester: writes TEST_WORDS words in bursts of BURST_LEN using
// one of four data patterns, reads them back one burst at a time and compares.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start, mode         one-cycle start request and pattern select
//   init_done           memory controller ready (only gates start)
//   avl                 Avalon master modport (command, write and read beats)
//   busy/complete/pass/fail/timeout  test status
//   err_count           saturating mismatch count
//   first_err_addr      word index of the first mismatch
module avl_mem_tester #(
    parameter int unsigned ADDR_W     = 27,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BURST_LEN  = 1,
    parameter int unsigned TEST_WORDS = 1024,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              init_done,
    avl_mem_tester_if.master  avl,
    output logic              busy,
    output logic              complete,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam int unsigned IDX_W  = $clog2(TEST_WORDS + 1);
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned BEAT_W = 3;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TEST_WORDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT - 1);
    localparam logic [31:0]       LFSR_SEED = 32'hACE1_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_CMD,
        S_RD_WAIT,
        S_DONE
    } state_e;

    // Fibonacci LFSR, taps 32,22,2,1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Expected data for word index i; l is the LFSR value belonging to i
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]       m,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [31:0]      l);
        logic [DATA_W-1:0] iw;
        logic [DATA_W-1:0] p;
        int unsigned       sh;
        iw = DATA_W'(i);
        sh = 32'(i) % DATA_W;
        case (m)
            2'b00:   p = iw;
            2'b01:   p = DATA_W'(1) << sh;
            2'b10:   p = DATA_W'(l);
            default: p = ~iw;
        endcase
        return p;
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              bb_q, bb_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              complete_q, complete_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;

    logic [IDX_W-1:0]  idx_inc;
    logic [31:0]       lfsr_inc;
    logic              rd_mismatch;
    logic              progress;

    assign idx_inc     = idx_q + IDX_W'(1);
    assign lfsr_inc    = lfsr_step(lfsr_q);
    assign rd_mismatch = (avl.avl_readdata != pattern(mode_q, idx_q, lfsr_q));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'b00;
            idx_q      <= '0;
            beat_q     <= '0;
            lfsr_q     <= '0;
            wd_q       <= '0;
            addr_q     <= '0;
            bb_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= '0;
            ferr_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            lfsr_q     <= lfsr_d;
            wd_q       <= wd_d;
            addr_q     <= addr_d;
            bb_q       <= bb_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        beat_d     = beat_q;
        lfsr_d     = lfsr_q;
        wd_d       = wd_q;
        addr_d     = addr_q;
        bb_d       = bb_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        complete_d = complete_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
        progress   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && init_done) begin
                    state_d    = S_WRITE;
                    mode_d     = mode;
                    idx_d      = '0;
                    beat_d     = '0;
                    lfsr_d     = LFSR_SEED;
                    wd_d       = '0;
                    addr_d     = '0;
                    bb_d       = 1'b1;
                    wr_d       = 1'b1;
                    rd_d       = 1'b0;
                    wdata_d    = pattern(mode, '0, LFSR_SEED);
                    busy_d     = 1'b1;
                    complete_d = 1'b0;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    timeout_d  = 1'b0;
                    err_d      = '0;
                    ferr_d     = '0;
                end
            end

            S_WRITE: begin
                if (avl.avl_waitrequest_n) begin
                    progress = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Last beat written: restart the generator for read-back
                        state_d = S_RD_CMD;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                        bb_d    = 1'b1;
                        addr_d  = '0;
                        idx_d   = '0;
                        beat_d  = '0;
                        lfsr_d  = LFSR_SEED;
                    end else begin
                        idx_d   = idx_inc;
                        lfsr_d  = lfsr_inc;
                        wdata_d = pattern(mode_q, idx_inc, lfsr_inc);
                        if (beat_q == LAST_BEAT) begin
                            beat_d = '0;
                            bb_d   = 1'b1;
                            addr_d = ADDR_W'(idx_inc);
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                            bb_d   = 1'b0;
                        end
                    end
                end
            end

            S_RD_CMD: begin
                if (avl.avl_waitrequest_n) begin
                    progress = 1'b1;
                    state_d  = S_RD_WAIT;
                    rd_d     = 1'b0;
                    bb_d     = 1'b0;
                    beat_d   = '0;
                end
            end

            S_RD_WAIT: begin
                if (avl.avl_readdatavalid) begin
                    progress = 1'b1;
                    if (rd_mismatch) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                        if (err_q == 16'd0) begin
                            ferr_d = ADDR_W'(idx_q);
                        end
                    end
                    idx_d  = idx_inc;
                    lfsr_d = lfsr_inc;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d    = S_DONE;
                            busy_d     = 1'b0;
                            complete_d = 1'b1;
                            pass_d     = (err_d == 16'd0);
                            fail_d     = (err_d != 16'd0);
                        end else begin
                            state_d = S_RD_CMD;
                            rd_d    = 1'b1;
                            bb_d    = 1'b1;
                            addr_d  = ADDR_W'(idx_inc);
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Watchdog: any cycle without a handshake or read beat counts as idle
        if (state_q inside {S_WRITE, S_RD_CMD, S_RD_WAIT}) begin
            if (progress) begin
                wd_d = '0;
            end else if (wd_q == WD_LIMIT) begin
                state_d    = S_DONE;
                wr_d       = 1'b0;
                rd_d       = 1'b0;
                bb_d       = 1'b0;
                timeout_d  = 1'b1;
                busy_d     = 1'b0;
                complete_d = 1'b1;
                pass_d     = 1'b0;
                fail_d     = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    assign avl.avl_address    = addr_q;
    assign avl.avl_burstbegin = bb_q;
    assign avl.avl_burstcount = 3'(BURST_LEN);
    assign avl.avl_write      = wr_q;
    assign avl.avl_read       = rd_q;
    assign avl.avl_writedata  = wdata_q;

    assign busy           = busy_q;
    assign complete       = complete_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_avl_mem_tester.sv
// Bench for avl_mem_tester: a behavioural Avalon memory slave with stall,
// corruption and silence knobs, and a pattern model computed per word index.
module tb_avl_mem_tester;
    localparam int unsigned ADDR_W     = 27;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BURST_LEN  = 4;
    localparam int unsigned TEST_WORDS = 16;
    localparam int unsigned TIMEOUT    = 64;
    localparam logic [31:0] SEED       = 32'hACE1_0001;

    logic              clk;
    logic              reset;
    logic              start;
    logic [1:0]        mode;
    logic              init_done;
    logic              busy, complete, pass, fail, timeout;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;

    avl_mem_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avl_mem_tester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .TEST_WORDS(TEST_WORDS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .init_done(init_done),
        .avl(bus.master),
        .busy(busy), .complete(complete), .pass(pass), .fail(fail), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Slave knobs (written only by the main sequence)
    int                stall_mode = 0;   // 0 none, 1 every other cycle, 2 random
    bit                no_rdv     = 1'b0;
    bit                spur_en    = 1'b0;
    logic [DATA_W-1:0] cmask [TEST_WORDS];

    // Slave state and logs (written only by the slave process)
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              bb;
        logic [DATA_W-1:0] data;
    } wbeat_t;
    wbeat_t                  wlog [$];
    logic [ADDR_W-1:0]       rlog [$];
    int                      rpend [$];
    logic [DATA_W-1:0]       mem [TEST_WORDS];
    int                      hold_viol = 0;
    int                      rdacc_cyc = 0;
    int                      wbase = 0;
    int                      wcnt = 0;
    bit                      phase = 1'b0;
    bit                      held_valid = 1'b0;
    logic [ADDR_W+DATA_W+2:0] held_vec;
    logic                    wn;
    int                      pidx;
    wbeat_t                  wb;

    // Memory slave: decides inputs at negedge, logs the handshakes of the next edge
    initial begin
        bus.avl_waitrequest_n = 1'b0;
        bus.avl_readdatavalid = 1'b0;
        bus.avl_readdata      = '0;
        forever begin
            @(negedge clk);
            if (held_valid &&
                {bus.avl_write, bus.avl_read, bus.avl_burstbegin, bus.avl_address, bus.avl_writedata} !== held_vec)
                hold_viol++;
            case (stall_mode)
                0:       wn = 1'b1;
                1:       begin phase = !phase; wn = phase; end
                default: wn = ($urandom_range(0, 3) != 0);
            endcase
            bus.avl_waitrequest_n = wn;
            bus.avl_readdatavalid = 1'b0;
            bus.avl_readdata      = $urandom();
            if (no_rdv) begin
                rpend.delete();
            end else if (rpend.size() > 0 && (stall_mode != 2 || $urandom_range(0, 2) != 0)) begin
                pidx = rpend.pop_front();
                bus.avl_readdatavalid = 1'b1;
                bus.avl_readdata = (pidx < TEST_WORDS) ? (mem[pidx] ^ cmask[pidx]) : '0;
            end else if (spur_en && bus.avl_write) begin
                bus.avl_readdatavalid = 1'b1;
                bus.avl_readdata      = 32'hDEAD_BEEF;
            end
            held_valid = (bus.avl_write || bus.avl_read) && !wn;
            held_vec   = {bus.avl_write, bus.avl_read, bus.avl_burstbegin, bus.avl_address, bus.avl_writedata};
            if (bus.avl_write && wn) begin
                if (bus.avl_burstbegin) begin
                    wbase = int'(bus.avl_address);
                    wcnt  = 0;
                end
                wb.addr = bus.avl_address;
                wb.bb   = bus.avl_burstbegin;
                wb.data = bus.avl_writedata;
                wlog.push_back(wb);
                if (wbase + wcnt < TEST_WORDS) mem[wbase + wcnt] = bus.avl_writedata;
                wcnt++;
            end
            if (bus.avl_read && wn) begin
                rlog.push_back(bus.avl_address);
                rdacc_cyc = cyc + 1;
                for (int k = 0; k < BURST_LEN; k++) rpend.push_back(int'(bus.avl_address) + k);
            end
        end
    end

    // Reference pattern for word i, straight from the pattern definitions
    function automatic logic [DATA_W-1:0] exp_data(input logic [1:0] m, input int i);
        logic [31:0] s;
        s = SEED;
        for (int k = 0; k < i; k++) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        case (m)
            2'b00:   return DATA_W'(i);
            2'b01:   return DATA_W'(1) << (i % DATA_W);
            2'b10:   return DATA_W'(s);
            default: return ~DATA_W'(i);
        endcase
    endfunction

    task automatic clear_cmask();
        for (int i = 0; i < TEST_WORDS; i++) cmask[i] = '0;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full write/read-back run, checked against the model and the corruption masks
    task automatic run_test(input string name, input logic [1:0] m, input bit poke);
        int                w0, r0, h0, exp_err;
        logic [ADDR_W-1:0] exp_first;
        bit                got_first, done;
        logic [ADDR_W-1:0] ea;
        w0 = wlog.size(); r0 = rlog.size(); h0 = hold_viol;
        exp_err = 0; exp_first = '0; got_first = 1'b0;
        for (int i = 0; i < TEST_WORDS; i++) begin
            if (cmask[i] != '0) begin
                exp_err++;
                if (!got_first) begin exp_first = ADDR_W'(i); got_first = 1'b1; end
            end
        end
        pulse_start(m);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (poke && c == 6) begin start = 1'b1; mode = ~m; init_done = 1'b0; end
            else if (poke && c == 7) start = 1'b0;
            done = (complete === 1'b1);
        end
        init_done = 1'b1;
        checks++;
        if (!done) begin errors++; $display("FAIL %s completion: got complete=%b want 1", name, complete); end
        checks++;
        if (wlog.size() - w0 != TEST_WORDS) begin
            errors++; $display("FAIL %s write_count: got %0d want %0d", name, wlog.size() - w0, TEST_WORDS);
        end
        for (int k = 0; k < TEST_WORDS && w0 + k < wlog.size(); k++) begin
            ea = ADDR_W'(k - (k % BURST_LEN));
            checks++;
            if (wlog[w0+k].addr !== ea || wlog[w0+k].bb !== (k % BURST_LEN == 0) || wlog[w0+k].data !== exp_data(m, k)) begin
                errors++;
                $display("FAIL %s write_beat%0d: got addr=%0d bb=%b data=%h want addr=%0d bb=%b data=%h", name, k,
                         wlog[w0+k].addr, wlog[w0+k].bb, wlog[w0+k].data, ea, (k % BURST_LEN == 0), exp_data(m, k));
            end
        end
        checks++;
        if (rlog.size() - r0 != TEST_WORDS / BURST_LEN) begin
            errors++; $display("FAIL %s read_cmds: got %0d want %0d", name, rlog.size() - r0, TEST_WORDS / BURST_LEN);
        end
        for (int j = 0; j < TEST_WORDS / BURST_LEN && r0 + j < rlog.size(); j++) begin
            checks++;
            if (rlog[r0+j] !== ADDR_W'(j * BURST_LEN)) begin
                errors++; $display("FAIL %s read_addr%0d: got %0d want %0d", name, j, rlog[r0+j], j * BURST_LEN);
            end
        end
        checks++;
        if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL %s err_count: got %0d want %0d", name, err_count, exp_err); end
        checks++;
        if (first_err_addr !== exp_first) begin
            errors++; $display("FAIL %s first_err_addr: got %0d want %0d", name, first_err_addr, exp_first);
        end
        checks++;
        if ({pass, fail, timeout, busy} !== {exp_err == 0, exp_err != 0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL %s status: got pass=%b fail=%b timeout=%b busy=%b want pass=%b fail=%b timeout=0 busy=0",
                               name, pass, fail, timeout, busy, exp_err == 0, exp_err != 0);
        end
        checks++;
        if (hold_viol != h0) begin errors++; $display("FAIL %s stall_hold: got %0d changes want 0", name, hold_viol - h0); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 2'b00; init_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, complete, pass, fail, timeout, err_count, first_err_addr} !== '0) begin
            errors++; $display("FAIL reset_status: got busy=%b complete=%b pass=%b fail=%b timeout=%b err=%0d ferr=%0d want all 0",
                               busy, complete, pass, fail, timeout, err_count, first_err_addr);
        end
        checks++;
        if ({bus.avl_write, bus.avl_read, bus.avl_burstbegin, bus.avl_address, bus.avl_writedata} !== '0) begin
            errors++; $display("FAIL reset_bus: got wr=%b rd=%b bb=%b addr=%0d wdata=%h want all 0",
                               bus.avl_write, bus.avl_read, bus.avl_burstbegin, bus.avl_address, bus.avl_writedata);
        end
        checks++;
        if (bus.avl_burstcount !== 3'(BURST_LEN)) begin
            errors++; $display("FAIL reset_burstcount: got %0d want %0d", bus.avl_burstcount, BURST_LEN);
        end
        reset = 1'b0;
        init_done = 1'b0;
        pulse_start(2'b00);
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, complete, bus.avl_write} !== 3'b000) begin
            errors++; $display("FAIL idle_no_init_start: got busy=%b complete=%b wr=%b want 0 0 0", busy, complete, bus.avl_write);
        end
        init_done = 1'b1;
    endtask

    task automatic test_patterns();
        for (int m = 0; m < 4; m++) begin
            clear_cmask();
            if ($urandom_range(0, 1) != 0) begin
                for (int n = 0; n < 2; n++) cmask[$urandom_range(0, TEST_WORDS - 1)] = $urandom() | 32'h1;
            end
            stall_mode = 2;
            spur_en    = (m == 0);
            run_test($sformatf("pattern_m%0d", m), 2'(m), 1'b0);
        end
        spur_en = 1'b0;
    endtask

    task automatic test_burst_stall();
        clear_cmask();
        stall_mode = 1;
        run_test("burst_stall", 2'b00, 1'b0);
    endtask

    task automatic test_walk_corrupt5();
        clear_cmask();
        cmask[5]   = 32'h1;
        stall_mode = 0;
        run_test("walk_corrupt5", 2'b01, 1'b0);
        clear_cmask();
    endtask

    // Runs right after walk_corrupt5, so DONE holds err=1, first=5, fail=1
    task automatic test_start_ignored();
        init_done = 1'b0;
        pulse_start(2'b00);
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, complete, pass, fail, err_count, first_err_addr} !== {1'b0, 1'b1, 1'b0, 1'b1, 16'd1, ADDR_W'(5)}) begin
            errors++; $display("FAIL done_no_init_start: got busy=%b complete=%b pass=%b fail=%b err=%0d ferr=%0d want 0 1 0 1 1 5",
                               busy, complete, pass, fail, err_count, first_err_addr);
        end
        init_done = 1'b1;
    endtask

    task automatic test_start_while_busy();
        clear_cmask();
        stall_mode = 2;
        run_test("busy_restart", 2'b10, 1'b1);
    endtask

    task automatic test_timeout();
        bit done;
        clear_cmask();
        stall_mode = 0;
        no_rdv     = 1'b1;
        pulse_start(2'b11);
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            done = (complete === 1'b1);
        end
        checks++;
        if (!done) begin errors++; $display("FAIL timeout_completion: got complete=%b want 1", complete); end
        checks++;
        if (cyc - rdacc_cyc != TIMEOUT) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles want %0d", cyc - rdacc_cyc, TIMEOUT);
        end
        checks++;
        if ({timeout, fail, pass, busy, err_count, bus.avl_read, bus.avl_write} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL timeout_status: got to=%b fail=%b pass=%b busy=%b err=%0d rd=%b wr=%b want 1 1 0 0 0 0 0",
                               timeout, fail, pass, busy, err_count, bus.avl_read, bus.avl_write);
        end
        no_rdv = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int  w0, w1;
        bit  hit;
        stall_mode = 1;
        w0 = wlog.size();
        pulse_start(2'b01);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            hit = (wlog.size() - w0 >= 2);
        end
        checks++;
        if (!hit || bus.avl_write !== 1'b1) begin
            errors++; $display("FAIL midburst_reach: got beats=%0d wr=%b want >=2 and 1", wlog.size() - w0, bus.avl_write);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, complete, pass, fail, timeout, err_count, first_err_addr,
             bus.avl_write, bus.avl_read, bus.avl_burstbegin, bus.avl_address, bus.avl_writedata} !== '0) begin
            errors++; $display("FAIL midburst_reset: got busy=%b wr=%b bb=%b addr=%0d wdata=%h want all 0",
                               busy, bus.avl_write, bus.avl_burstbegin, bus.avl_address, bus.avl_writedata);
        end
        checks++;
        if (bus.avl_burstcount !== 3'(BURST_LEN)) begin
            errors++; $display("FAIL midburst_burstcount: got %0d want %0d", bus.avl_burstcount, BURST_LEN);
        end
        reset = 1'b0;
        @(negedge clk);
        stall_mode = 2;
        w1 = wlog.size();
        run_test("rerun_lfsr", 2'b10, 1'b0);
        checks++;
        if (wlog.size() <= w1 || wlog[w1].data !== 32'hACE1_0001) begin
            errors++; $display("FAIL rerun_first_beat: got %h want acе10001", (wlog.size() > w1) ? wlog[w1].data : '0);
        end
    endtask

    initial begin
        clear_cmask();
        test_reset();
        test_patterns();
        test_burst_stall();
        test_walk_corrupt5();
        test_start_ignored();
        test_start_while_busy();
        test_timeout();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/avl_mem_tester.md
AVL_MEM_TESTER -- requirements
Module: avl_mem_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, meaning Avalon word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width (8..64).
REQ-003 SHALL have parameter BURST_LEN, default 1, meaning beats per burst (1..7).
REQ-004 SHALL have parameter TEST_WORDS, default 1024, meaning words tested; it is a multiple of BURST_LEN.
REQ-005 SHALL have parameter TIMEOUT, default 4096, meaning maximum cycles without progress.
REQ-006 SHALL have the following ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock for all logic.
  reset  in  1  synchronous, active-high.
  start  in  1  one-cycle test start request.
  mode  in  2  pattern: 00 addr-as-data, 01 walking-ones, 10 LFSR, 11 inverted addr.
  init_done  in  1  memory controller ready.
  avl_waitrequest_n  in  1  slave accepts command/beat.
  avl_address  out  ADDR_W  burst start word address.
  avl_burstbegin  out  1  first beat of a write burst, or read command.
  avl_burstcount  out  3  constant BURST_LEN.
  avl_write / avl_read  out  1  command strobes.
  avl_writedata  out  DATA_W  write beat.
  avl_readdatavalid  in  1  read beat valid.
  avl_readdata  in  DATA_W  read beat.
  busy, complete, pass, fail, timeout  out  1  status.
  err_count  out  16  mismatch count.
  first_err_addr  out  ADDR_W  word index of first mismatch.

Function
REQ-007 SHALL implement states IDLE, WRITE, RD_CMD, RD_WAIT, DONE.
REQ-008 SHALL accept start only in IDLE or DONE with init_done=1; in all other cases start is ignored.
REQ-009 On accepted start: latch mode, clear counters/status, set busy, go to WRITE next cycle.
REQ-010 In WRITE: assert avl_write with word index i, avl_address = burst base, and avl_burstbegin on the first beat of each burst only; hold all outputs while avl_waitrequest_n=0; advance i only on an accepted beat.
REQ-011 After beat TEST_WORDS-1 is accepted, deassert avl_write and go to RD_CMD; restart the pattern generator at i=0.
REQ-012 In RD_CMD: assert avl_read plus avl_burstbegin at the burst base, held until avl_waitrequest_n=1, then go to RD_WAIT; exactly one read burst is outstanding.
REQ-013 In RD_WAIT: on each avl_readdatavalid, compare avl_readdata against expected(i) and increment i.
REQ-014 After BURST_LEN beats, go to RD_CMD, or to DONE if i=TEST_WORDS.
REQ-015 Patterns, with i the zero-extended word index truncated/extended to DATA_W:
  00: i.
  01: 1 << (i mod DATA_W).
  10: 32-bit Fibonacci LFSR, taps 32,22,2,1, seed 32'hACE10001, stepped once per beat, zero-extended/truncated to DATA_W.
  11: ~i.
REQ-016 On mismatch: err_count increments, saturating at 16'hFFFF; first_err_addr captures i only on the first mismatch.
REQ-017 Watchdog: counts cycles in WRITE/RD_CMD/RD_WAIT without an accepted beat or readdatavalid; at TIMEOUT it sets timeout=1 and goes to DONE, dropping the strobes.
REQ-018 In DONE: busy=0 and complete=1; pass = (err_count==0 & !timeout); fail = !pass. These outputs are held until the next accepted start or reset.
REQ-019 A readdatavalid arriving outside RD_WAIT SHALL be ignored.
REQ-020 If init_done falls during a test, the test continues; no abort is required.

Reset
REQ-021 reset SHALL, on the next clk edge, force IDLE and drive all strobes, status, err_count, first_err_addr, avl_address and avl_writedata to 0, regardless of state (including mid-burst).
REQ-022 avl_burstcount SHALL equal BURST_LEN at all times, including during reset.

Verification
REQ-023 Ideal slave with BURST_LEN=1, TEST_WORDS=16, mode 00 -> 16 writes with data 0..15, then 16 reads; complete=1, pass=1, err_count=0.
REQ-024 BURST_LEN=4 and waitrequest_n low on every other cycle -> address advances 0,4,8,12; burstbegin only on beats 0,4,8,12; data is unchanged while stalled.
REQ-025 Mode 01 with slave corrupting word 5 (bit 0 flipped) -> err_count=1, first_err_addr=5, fail=1.
REQ-026 Slave never returns readdatavalid, TIMEOUT=64 -> timeout=1 and fail=1 after 64 idle cycles in RD_WAIT.
REQ-027 reset asserted mid-write-burst, then start -> all outputs 0 one cycle after reset; the rerun passes with mode 10 (first beat 32'hACE10001).
REQ-028 start while busy, or with init_done=0 -> ignored; status is unchanged.
